// File: rtl/lr_dot_mac_pkg.sv
// Shared definitions for the linear-regression dot-product engine:
// default word format, saturation bounds and control FSM encoding.
`ifndef LR_DOT_MAC_PKG_SV
`define LR_DOT_MAC_PKG_SV
package lr_dot_mac_pkg;

  localparam int WIDTH_DEF    = 32;
  localparam int FRACTION_DEF = 16;

  localparam logic [WIDTH_DEF-1:0] FP_MAX = {1'b0, {(WIDTH_DEF-1){1'b1}}};
  localparam logic [WIDTH_DEF-1:0] FP_MIN = {1'b1, {(WIDTH_DEF-1){1'b0}}};

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage
`endif

// File: rtl/lr_dot_mac_fp.sv
// Saturating signed fixed-point arithmetic: fp_mul (round-to-nearest product)
// and fp_add. Both are purely combinational and flag saturation.
module fp_mul
  import lr_dot_mac_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int FRACTION = FRACTION_DEF
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] y,
  output logic                    sat
);
  localparam int PW = 2*WIDTH + 1;
  localparam logic signed [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [PW-1:0] prod, rnd, shf;

  always_comb begin
    prod = PW'(a) * PW'(b);
    // half-LSB bias then arithmetic shift gives round-to-nearest
    rnd  = prod + (PW'(1) <<< (FRACTION-1));
    shf  = rnd >>> FRACTION;
    sat  = 1'b0;
    y    = shf[WIDTH-1:0];
    if (shf > PW'(MAX_W)) begin
      y   = MAX_W;
      sat = 1'b1;
    end else if (shf < PW'(MIN_W)) begin
      y   = MIN_W;
      sat = 1'b1;
    end
  end
endmodule

module fp_add
  import lr_dot_mac_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] y,
  output logic                    sat
);
  localparam logic signed [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH:0] sum;

  always_comb begin
    sum = (WIDTH+1)'(a) + (WIDTH+1)'(b);
    sat = sum[WIDTH] ^ sum[WIDTH-1];
    y   = sum[WIDTH-1:0];
    if (sat) y = sum[WIDTH] ? MIN_W : MAX_W;
  end
endmodule

// File: rtl/lr_dot_mac.sv
// Streaming dot-product engine: y = bias + sum(x_i * w_i), one beat per clock.
// Optional beat-count check enabled by defining LR_DOT_MAC_LENCHK_EN.
module lr_dot_mac
  import lr_dot_mac_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int FRACTION = FRACTION_DEF,
  parameter int N_FEAT   = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_x,
  input  logic [WIDTH-1:0] s_w,
  input  logic             s_last,
  input  logic [WIDTH-1:0] bias,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_y,
  output logic             o_sat,
  output logic             o_len_err,
  output logic             busy
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             sat_acc_q, sat_acc_d;
  logic             first_q, first_d;
  logic             busy_q, busy_d;
  logic             o_valid_q, o_valid_d;
  logic [WIDTH-1:0] o_y_q, o_y_d;
  logic             o_sat_q, o_sat_d;

  logic             accept;
  logic [WIDTH-1:0] prod, addend, sum;
  logic             mul_sat, add_sat, sat_new;

  assign s_ready = (state_q == ACCUM);
  assign accept  = s_valid && s_ready;
  assign addend  = first_q ? bias : acc_q;
  assign sat_new = (first_q ? 1'b0 : sat_acc_q) | mul_sat | add_sat;

  fp_mul #(.WIDTH(WIDTH), .FRACTION(FRACTION)) u_mul (
    .a(s_x), .b(s_w), .y(prod), .sat(mul_sat)
  );

  fp_add #(.WIDTH(WIDTH)) u_add (
    .a(addend), .b(prod), .y(sum), .sat(add_sat)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    sat_acc_d = sat_acc_q;
    first_d   = first_q;
    busy_d    = busy_q;
    o_valid_d = o_valid_q;
    o_y_d     = o_y_q;
    o_sat_d   = o_sat_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d     = sum;
          sat_acc_d = sat_new;
          first_d   = 1'b0;
          busy_d    = 1'b1;
          if (s_last) begin
            state_d   = HOLD;
            o_valid_d = 1'b1;
            o_y_d     = sum;
            o_sat_d   = sat_new;
          end
        end
      end
      HOLD: begin
        if (o_valid_q && o_ready) begin
          o_valid_d = 1'b0;
          busy_d    = 1'b0;
          first_d   = 1'b1;
          state_d   = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      sat_acc_q <= 1'b0;
      first_q   <= 1'b1;
      busy_q    <= 1'b0;
      o_valid_q <= 1'b0;
      o_y_q     <= '0;
      o_sat_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      sat_acc_q <= sat_acc_d;
      first_q   <= first_d;
      busy_q    <= busy_d;
      o_valid_q <= o_valid_d;
      o_y_q     <= o_y_d;
      o_sat_q   <= o_sat_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_y     = o_y_q;
  assign o_sat   = o_sat_q;
  assign busy    = busy_q;

  // Counter too narrow to hold N_FEAT: elaborates an empty marker block only.
  if (N_FEAT >= (1 << CNT_W)) begin : g_cnt_w_too_small
  end

`ifdef LR_DOT_MAC_LENCHK_EN
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
  logic             len_err_q, len_err_d;

  always_comb begin
    cnt_nxt   = first_q ? CNT_W'(1) :
                (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    cnt_d     = cnt_q;
    len_err_d = len_err_q;
    if (accept) begin
      cnt_d = cnt_nxt;
      if (s_last) len_err_d = (cnt_nxt != CNT_W'(N_FEAT));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end

  assign o_len_err = len_err_q;
`else
  assign o_len_err = 1'b0;
`endif

endmodule
